// File: rtl/mips_pkg.sv
// Shared types and widths for the multicycle MIPS datapath blocks.
package mips_pkg;

    localparam int unsigned MD_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV,
        FIX,
        DZERO
    } md_state_t;

    typedef enum logic {
        OP_MULT,
        OP_DIV
    } md_op_t;

endpackage

// File: rtl/md_sign_fix.sv
// Turns the unsigned magnitude result of a MULT or DIV into two's-complement Hi/Lo values.
module md_sign_fix
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic                 div_i,
    input  logic                 neg_i,
    input  logic                 rem_neg_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    output logic [WIDTH-1:0]     hi_c_o,
    output logic [WIDTH-1:0]     lo_c_o
);

    logic [2*WIDTH-1:0] prod_c;
    logic [WIDTH-1:0]   quo_c;
    logic [WIDTH-1:0]   rem_c;

    // Quotient follows sign(A)^sign(B); remainder follows the dividend.
    always_comb begin
        prod_c = neg_i ? -acc_i : acc_i;
        quo_c  = neg_i ? -acc_i[WIDTH-1:0] : acc_i[WIDTH-1:0];
        rem_c  = rem_neg_i ? -acc_i[2*WIDTH-1:WIDTH] : acc_i[2*WIDTH-1:WIDTH];
        if (div_i) begin
            hi_c_o = rem_c;
            lo_c_o = quo_c;
        end else begin
            hi_c_o = prod_c[2*WIDTH-1:WIDTH];
            lo_c_o = prod_c[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed MULT/DIV unit writing HI/LO: one bit per cycle on magnitudes,
// followed by a single sign-correction cycle.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start_Mult,
    input  logic             Start_Div,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done,
    output logic             Div_Zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    md_state_t           state_q, state_d;
    md_op_t              op_q, op_d;
    logic                neg_q, neg_d;
    logic                rneg_q, rneg_d;
    logic [WIDTH-1:0]    a_mag_q, a_mag_d;
    logic [WIDTH-1:0]    b_mag_q, b_mag_d;
    logic [2*WIDTH-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    hi_q, hi_d;
    logic [WIDTH-1:0]    lo_q, lo_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                dz_q, dz_d;

    logic [WIDTH-1:0]    a_abs_c;
    logic [WIDTH-1:0]    b_abs_c;
    logic [WIDTH:0]      mul_sum_c;
    logic [WIDTH:0]      div_sh_c;
    logic [WIDTH:0]      div_diff_c;
    logic [WIDTH-1:0]    fix_hi_c;
    logic [WIDTH-1:0]    fix_lo_c;

    // Magnitudes are unsigned, so |-2^(WIDTH-1)| = 2^(WIDTH-1) fits in WIDTH bits.
    always_comb begin
        a_abs_c    = A[WIDTH-1] ? -A : A;
        b_abs_c    = B[WIDTH-1] ? -B : B;
        mul_sum_c  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_mag_q} : '0);
        div_sh_c   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff_c = div_sh_c - {1'b0, b_mag_q};
    end

    md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .div_i     (op_q == OP_DIV),
        .neg_i     (neg_q),
        .rem_neg_i (rneg_q),
        .acc_i     (acc_q),
        .hi_c_o    (fix_hi_c),
        .lo_c_o    (fix_lo_c)
    );

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= IDLE;
            op_q    <= OP_MULT;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            a_mag_q <= '0;
            b_mag_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            a_mag_q <= a_mag_d;
            b_mag_q <= b_mag_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        a_mag_d = a_mag_q;
        b_mag_d = b_mag_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        case (state_q)
            IDLE: begin
                if (Start_Mult || Start_Div) begin
                    op_d    = Start_Mult ? OP_MULT : OP_DIV;
                    a_mag_d = a_abs_c;
                    b_mag_d = b_abs_c;
                    neg_d   = A[WIDTH-1] ^ B[WIDTH-1];
                    rneg_d  = A[WIDTH-1];
                    cnt_d   = '0;
                    dz_d    = 1'b0;
                    busy_d  = 1'b1;
                    if (Start_Mult) begin
                        acc_d   = {{WIDTH{1'b0}}, b_abs_c};
                        state_d = MUL;
                    end else if (B == '0) begin
                        state_d = DZERO;
                    end else begin
                        acc_d   = {{WIDTH{1'b0}}, a_abs_c};
                        state_d = DIV;
                    end
                end
            end
            MUL: begin
                acc_d = {mul_sum_c, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end
            end
            DIV: begin
                if (!div_diff_c[WIDTH]) begin
                    acc_d = {div_diff_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {div_sh_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                hi_d    = fix_hi_c;
                lo_d    = fix_lo_c;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            DZERO: begin
                dz_d    = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Hi       = hi_q;
    assign Lo       = lo_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Div_Zero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed corner cases plus random MULT/DIV traffic.
module tb_mult_div_unit;

    logic        Clk;
    logic        Reset;
    logic        Start_Mult;
    logic        Start_Div;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        Busy;
    logic        Done;
    logic        Div_Zero;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    int          checks;
    int          failures;

    mult_div_unit #(.WIDTH(32)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start_Mult (Start_Mult),
        .Start_Div  (Start_Div),
        .A          (A),
        .B          (B),
        .Hi         (Hi),
        .Lo         (Lo),
        .Busy       (Busy),
        .Done       (Done),
        .Div_Zero   (Div_Zero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every Done pulse must match the oldest outstanding expectation.
    always @(negedge Clk) begin
        if (Reset) begin
            check("busy_done_exclusive", 64'(Busy & Done), 64'd0);
            if (Done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 64'(Done), 64'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("hi", 64'(Hi), 64'(e.hi));
                    check("lo", 64'(Lo), 64'(e.lo));
                    check("div_zero", 64'(Div_Zero), 64'(e.dz));
                end
            end
        end
    end

    // Reference: signed 64-bit arithmetic; SV / and % truncate toward zero.
    task automatic issue(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                         input int poke, input bit both);
        exp_t        e;
        longint      sa, sb;
        logic [63:0] p;
        int          cyc;
        int          exp_lat;
        bit          run_div;
        run_div = is_div && !both;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!run_div) begin
            p    = 64'(sa * sb);
            m_hi = p[63:32];
            m_lo = p[31:0];
            e    = '{m_hi, m_lo, 1'b0};
        end else if (b == 32'd0) begin
            e    = '{m_hi, m_lo, 1'b1};
        end else begin
            m_lo = 32'(sa / sb);
            m_hi = 32'(sa % sb);
            e    = '{m_hi, m_lo, 1'b0};
        end
        sb_q.push_back(e);
        exp_lat = (run_div && b == 32'd0) ? 1 : 33;

        @(negedge Clk);
        Start_Mult = !is_div || both;
        Start_Div  = is_div || both;
        A = a;
        B = b;
        @(negedge Clk);
        Start_Mult = 1'b0;
        Start_Div  = 1'b0;
        A = $urandom;
        B = $urandom;
        check("busy_after_accept", 64'(Busy), 64'd1);
        check("dz_clear_at_accept", 64'(Div_Zero), 64'd0);
        cyc = 0;
        while (!Done && cyc < 100) begin
            @(negedge Clk);
            cyc++;
            Start_Mult = (cyc == poke);
        end
        Start_Mult = 1'b0;
        check("latency", 64'(cyc), 64'(exp_lat));
    endtask

    initial begin
        bit seen;
        Reset      = 1'b0;
        Start_Mult = 1'b0;
        Start_Div  = 1'b0;
        A          = '0;
        B          = '0;
        m_hi       = '0;
        m_lo       = '0;
        checks     = 0;
        failures   = 0;
        repeat (2) @(negedge Clk);
        check("rst_hi", 64'(Hi), 64'd0);
        check("rst_lo", 64'(Lo), 64'd0);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        check("rst_dz", 64'(Div_Zero), 64'd0);
        Reset = 1'b1;

        issue(1'b0, 32'd7, 32'd6, -1, 1'b0);
        issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 1'b0);
        issue(1'b0, 32'h80000000, 32'h80000000, -1, 1'b0);
        issue(1'b0, -32'sd3, 32'd5, -1, 1'b0);
        issue(1'b1, -32'sd7, 32'd2, -1, 1'b0);
        issue(1'b1, 32'd7, -32'sd2, -1, 1'b0);
        issue(1'b1, 32'h80000000, 32'hFFFFFFFF, -1, 1'b0);
        // Preload Hi=0x11, Lo=0x22, then divide by zero must leave them intact.
        issue(1'b1, 32'h2211, 32'h100, -1, 1'b0);
        issue(1'b1, 32'd5, 32'd0, -1, 1'b0);
        issue(1'b0, 32'd2, 32'd3, -1, 1'b0);
        issue(1'b1, 32'd1000, -32'sd7, 10, 1'b0);
        issue(1'b1, 32'd9, 32'd4, -1, 1'b1);

        // Abort a MULT in flight with reset.
        @(negedge Clk);
        Start_Mult = 1'b1;
        A = 32'd12345;
        B = 32'd678;
        @(negedge Clk);
        Start_Mult = 1'b0;
        repeat (14) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check("abort_busy", 64'(Busy), 64'd0);
        check("abort_done", 64'(Done), 64'd0);
        check("abort_hi", 64'(Hi), 64'd0);
        check("abort_lo", 64'(Lo), 64'd0);
        Reset = 1'b1;
        m_hi = '0;
        m_lo = '0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge Clk);
            if (Done) seen = 1'b1;
        end
        check("no_done_after_abort", 64'(seen), 64'd0);
        issue(1'b0, 32'd12345, 32'd678, -1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            int          r;
            r = $urandom_range(0, 9);
            a = $urandom;
            b = $urandom;
            if (r == 0) b = 32'd0;
            if (r == 1) a = 32'h80000000;
            if (r == 2) b = 32'hFFFFFFFF;
            if (r == 3) b = 32'($urandom_range(0, 40)) - 32'd20;
            issue(1'($urandom_range(0, 1)), a, b, -1, 1'b0);
        end

        repeat (3) @(negedge Clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
